// File: rtl/program_loader.sv
// Program loader: packs a byte stream into instructions, writes them to
// consecutive program-memory addresses and releases the CPU once HLT is stored.
module program_loader #(
    parameter int OPCODE  = 5,
    parameter int OPERAND = 11,
    parameter int ADDR    = 11,
    parameter int BYTE    = 8
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset_n,
    input  logic                      i_Start,
    input  logic [BYTE-1:0]           i_RxData,
    input  logic                      i_RxValid,
    output logic [ADDR-1:0]           o_MemAddr,
    output logic [OPCODE+OPERAND-1:0] o_MemData,
    output logic                      o_MemWe,
    output logic [ADDR:0]             o_InstCount,
    output logic                      o_Done,
    output logic                      o_Error,
    output logic                      o_CpuRun
);

    // state | meaning
    // IDLE  | after reset, byte stream ignored until i_Start
    // HIGH  | waiting for the high byte (opcode + operand msbs)
    // LOW   | waiting for the low byte; the write is issued on its arrival
    // DONE  | HLT stored, CPU released
    // ERROR | illegal opcode or address overflow, CPU held
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIGH  = 3'd1,
        S_LOW   = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam int                WORD      = OPCODE + OPERAND;
    localparam logic [OPCODE-1:0] OP_MAX    = OPCODE'(7);
    localparam logic [OPCODE-1:0] OP_HLT    = '0;
    localparam logic [ADDR-1:0]   ADDR_LAST = '1;
    localparam logic [ADDR-1:0]   ADDR_ONE  = ADDR'(1);
    localparam logic [ADDR:0]     CNT_ONE   = (ADDR+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic [ADDR:0]     count_q, count_d;
    logic [BYTE-1:0]   high_q, high_d;
    logic [WORD-1:0]   data_q, data_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              rx_take;
    logic [OPCODE-1:0] opcode_rx;
    logic [OPCODE-1:0] opcode_high;
    logic              illegal_rx;

    // A start pulse always wins over a coincident byte.
    assign rx_take     = i_RxValid & ~i_Start;
    assign opcode_rx   = i_RxData[BYTE-1 -: OPCODE];
    assign opcode_high = high_q[BYTE-1 -: OPCODE];
    assign illegal_rx  = (opcode_rx > OP_MAX);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_Start) state_d = S_HIGH;
            end
            S_HIGH: begin
                if (i_Start)      state_d = S_HIGH;
                else if (rx_take) state_d = illegal_rx ? S_ERROR : S_LOW;
            end
            S_LOW: begin
                if (i_Start) begin
                    state_d = S_HIGH;
                end else if (rx_take) begin
                    if (opcode_high == OP_HLT)  state_d = S_DONE;
                    else if (addr_q == ADDR_LAST) state_d = S_ERROR;
                    else                          state_d = S_HIGH;
                end
            end
            S_DONE, S_ERROR: begin
                if (i_Start) state_d = S_HIGH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags follow the registered state, so DONE and overflow ERROR
    // appear one cycle after the write pulse; illegal opcodes flag at once.
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        high_d  = high_q;
        data_d  = data_q;
        we_d    = 1'b0;
        if (we_q) begin
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q + CNT_ONE;
        end
        if (i_Start) begin
            addr_d  = '0;
            count_d = '0;
        end
        if (state_q == S_HIGH && rx_take) begin
            high_d = i_RxData;
        end
        if (state_q == S_LOW && rx_take) begin
            data_d = WORD'({high_q, i_RxData});
            we_d   = 1'b1;
        end
        done_d  = (state_q == S_DONE) && !i_Start;
        error_d = ((state_q == S_ERROR) && !i_Start)
               || ((state_q == S_HIGH) && rx_take && illegal_rx);
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            addr_q  <= '0;
            count_q <= '0;
            high_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            high_q  <= high_d;
            data_q  <= data_d;
            we_q    <= we_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign o_MemAddr   = addr_q;
    assign o_MemData   = data_q;
    assign o_MemWe     = we_q;
    assign o_InstCount = count_q;
    assign o_Done      = done_q;
    assign o_Error     = error_q;
    assign o_CpuRun    = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scoreboard of expected memory writes plus
// per-scenario cycle checks on a default instance and a 4-deep instance.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic [10:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic [11:0] inst_count;
    logic        done, error, cpu_run;

    logic [1:0]  mem_addr_s;
    logic [15:0] mem_data_s;
    logic        mem_we_s;
    logic [2:0]  inst_count_s;
    logic        done_s, error_s, cpu_run_s;

    int n_total = 0;
    int n_pass  = 0;

    logic [26:0] exp_q[$];
    logic [17:0] exp_s[$];
    logic [10:0] exp_addr = '0;
    logic [1:0]  exp_addr_s = '0;
    logic        mon_main_en = 1'b1;
    logic        mon_small_en = 1'b0;

    always #5 clk = ~clk;

    program_loader dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start),
        .i_RxData(rx_data), .i_RxValid(rx_valid),
        .o_MemAddr(mem_addr), .o_MemData(mem_data), .o_MemWe(mem_we),
        .o_InstCount(inst_count), .o_Done(done), .o_Error(error),
        .o_CpuRun(cpu_run)
    );

    program_loader #(.ADDR(2)) dut_s (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start),
        .i_RxData(rx_data), .i_RxValid(rx_valid),
        .o_MemAddr(mem_addr_s), .o_MemData(mem_data_s), .o_MemWe(mem_we_s),
        .o_InstCount(inst_count_s), .o_Done(done_s), .o_Error(error_s),
        .o_CpuRun(cpu_run_s)
    );

    always @(negedge clk) begin
        if (mon_main_en && mem_we === 1'b1) begin
            logic [26:0] e;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got %h@%0d, none required", mem_data, mem_addr);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_data} !== e)
                    $display("FAIL write: got %h@%0d exp %h@%0d", mem_data, mem_addr, e[15:0], e[26:16]);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_small_en && mem_we_s === 1'b1) begin
            logic [17:0] e;
            n_total++;
            if (exp_s.size() == 0) begin
                $display("FAIL unexpected_write_small: got %h@%0d, none required", mem_data_s, mem_addr_s);
            end else begin
                e = exp_s.pop_front();
                if ({mem_addr_s, mem_data_s} !== e)
                    $display("FAIL write_small: got %h@%0d exp %h@%0d", mem_data_s, mem_addr_s, e[15:0], e[17:16]);
                else n_pass++;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        exp_addr = '0;
        exp_addr_s = '0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk); rx_data = b; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic push_main(input logic [15:0] d);
        exp_q.push_back({exp_addr, d});
        exp_addr = exp_addr + 11'd1;
    endtask

    task automatic push_small(input logic [15:0] d);
        exp_s.push_back({exp_addr_s, d});
        exp_addr_s = exp_addr_s + 2'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        n_total++; if (mem_addr !== 11'd0) $display("FAIL rst_addr: got %0d exp 0", mem_addr); else n_pass++;
        n_total++; if (mem_data !== 16'h0) $display("FAIL rst_data: got %h exp 0", mem_data); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b exp 0", mem_we); else n_pass++;
        n_total++; if (inst_count !== 12'd0) $display("FAIL rst_count: got %0d exp 0", inst_count); else n_pass++;
        n_total++; if ({done, error, cpu_run} !== 3'b000) $display("FAIL rst_flags: got %b exp 000", {done, error, cpu_run}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        send(8'h00); send(8'h00);
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL idle_ignores_rx: done got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_load_basic();
        pulse_start();
        push_main(16'h1805); push_main(16'h2803); push_main(16'h0000);
        send(8'h18); send(8'h05); send(8'h28); send(8'h03); send(8'h00); send(8'h00);
        n_total++; if ({mem_we, done} !== 2'b10) $display("FAIL hlt_pulse: we,done got %b exp 10", {mem_we, done}); else n_pass++;
        n_total++; if (mem_addr !== 11'd2) $display("FAIL hlt_addr: got %0d exp 2", mem_addr); else n_pass++;
        @(negedge clk);
        n_total++; if ({mem_we, done, cpu_run, error} !== 4'b0110) $display("FAIL done_after_hlt: we,done,run,err got %b exp 0110", {mem_we, done, cpu_run, error}); else n_pass++;
        n_total++; if (inst_count !== 12'd3) $display("FAIL basic_count: got %0d exp 3", inst_count); else n_pass++;
        n_total++; if (mem_addr !== 11'd3) $display("FAIL basic_addr_after: got %0d exp 3", mem_addr); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL basic_missing_writes: got %0d pending exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_restart_abort();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; exp_addr = '0;
        n_total++; if ({cpu_run, done} !== 2'b00) $display("FAIL restart_drop_run: run,done got %b exp 00", {cpu_run, done}); else n_pass++;
        n_total++; if ({mem_addr, inst_count} !== 23'd0) $display("FAIL restart_clear: addr %0d count %0d exp 0 0", mem_addr, inst_count); else n_pass++;
        push_main(16'h3801); push_main(16'h0000);
        send(8'h38); send(8'h01); send(8'h00); send(8'h00);
        @(negedge clk);
        n_total++; if ({done, inst_count} !== {1'b1, 12'd2}) $display("FAIL restart_done: done %b count %0d exp 1 2", done, inst_count); else n_pass++;
        pulse_start();
        send(8'h18);
        pulse_start();
        n_total++; if ({mem_we, mem_addr, inst_count} !== 24'd0) $display("FAIL abort_clear: we %b addr %0d count %0d exp 0 0 0", mem_we, mem_addr, inst_count); else n_pass++;
        push_main(16'h0000);
        send(8'h00); send(8'h00);
        @(negedge clk);
        n_total++; if ({done, inst_count} !== {1'b1, 12'd1}) $display("FAIL abort_then_hlt: done %b count %0d exp 1 1", done, inst_count); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL abort_missing_writes: got %0d pending exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_illegal();
        pulse_start();
        push_main(16'h1805);
        send(8'h18); send(8'h05); send(8'h40);
        n_total++; if ({error, cpu_run} !== 2'b10) $display("FAIL illegal_error: err,run got %b exp 10", {error, cpu_run}); else n_pass++;
        send(8'h00); send(8'h00);
        @(negedge clk);
        n_total++; if ({error, done, inst_count} !== {2'b10, 12'd1}) $display("FAIL illegal_hold: err %b done %b count %0d exp 1 0 1", error, done, inst_count); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL illegal_missing_writes: got %0d pending exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_overflow();
        mon_main_en = 1'b0;
        mon_small_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            push_small(16'h2001);
            send(8'h20); send(8'h01);
        end
        n_total++; if ({mem_we_s, error_s} !== 2'b10) $display("FAIL ovf_last_pulse: we,err got %b exp 10", {mem_we_s, error_s}); else n_pass++;
        @(negedge clk);
        n_total++; if ({error_s, cpu_run_s, done_s} !== 3'b100) $display("FAIL ovf_error: err,run,done got %b exp 100", {error_s, cpu_run_s, done_s}); else n_pass++;
        n_total++; if (inst_count_s !== 3'd4) $display("FAIL ovf_count: got %0d exp 4", inst_count_s); else n_pass++;
        send(8'h20); send(8'h01);
        @(negedge clk);
        n_total++; if (inst_count_s !== 3'd4) $display("FAIL ovf_no_fifth: count got %0d exp 4", inst_count_s); else n_pass++;
        n_total++; if (exp_s.size() != 0) $display("FAIL ovf_missing_writes: got %0d pending exp 0", exp_s.size()); else n_pass++;
        mon_small_en = 1'b0;
        exp_q.delete();
        mon_main_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        pulse_start();
        push_main(16'h0000);
        @(negedge clk); rx_data = 8'h00; rx_valid = 1'b1;
        @(negedge clk);
        @(negedge clk); rx_valid = 1'b0;
        n_total++; if ({mem_we, done, mem_addr, mem_data} !== {2'b10, 11'd0, 16'h0}) $display("FAIL b2b_pulse: we %b done %b addr %0d data %h exp 1 0 0 0000", mem_we, done, mem_addr, mem_data); else n_pass++;
        @(negedge clk);
        n_total++; if ({mem_we, done} !== 2'b01) $display("FAIL b2b_after: we,done got %b exp 01", {mem_we, done}); else n_pass++;
        pulse_start();
        @(negedge clk); start = 1'b1; rx_valid = 1'b1; rx_data = 8'h18;
        @(negedge clk); start = 1'b0; rx_valid = 1'b0; exp_addr = '0;
        push_main(16'h0000);
        send(8'h00); send(8'h00);
        @(negedge clk);
        n_total++; if ({done, inst_count} !== {1'b1, 12'd1}) $display("FAIL collision: done %b count %0d exp 1 1", done, inst_count); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL collision_missing_writes: got %0d pending exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_midload();
        pulse_start();
        push_main(16'h1805);
        send(8'h18); send(8'h05);
        send(8'h28);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if ({mem_addr, mem_data, inst_count} !== 39'd0) $display("FAIL async_rst_regs: addr %0d data %h count %0d exp 0 0 0", mem_addr, mem_data, inst_count); else n_pass++;
        n_total++; if ({mem_we, done, error, cpu_run} !== 4'b0000) $display("FAIL async_rst_flags: got %b exp 0000", {mem_we, done, error, cpu_run}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        send(8'h00); send(8'h00);
        @(negedge clk);
        n_total++; if ({done, mem_we, inst_count} !== 14'd0) $display("FAIL post_rst_ignore: done %b we %b count %0d exp 0 0 0", done, mem_we, inst_count); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL midload_pending: got %0d pending exp 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_basic();
        test_restart_abort();
        test_illegal();
        test_overflow();
        test_back_to_back();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
